branch_redirect_ctrl: RTL
=========================

# branch_redirect_ctrl

Sequencing controller for the 5-stage pipeline's control-flow and load-use hazards. It consumes the EX-stage branch decision (`do_branch`, `jump`, target) and the ID-stage load-use hazard. It registers the redirect for one cycle to break the EX→PC timing path. It drives PC select/write, IF/ID write-enable and the IF/ID, ID/EX and EX/MEM flushes. It also keeps saturating performance counters for redirects and stall cycles.

## Interface
- `XLEN`, 32, PC/target width.
- `CNT_W`, 16, width of each performance counter.

- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `ex_valid`  in  1  EX stage holds a real, non-bubble instruction.
- `do_branch`  in  1  taken conditional branch resolved in EX (BEQ taken or BNE taken).
- `jump`  in  1  unconditional jump in EX.
- `ex_target`  in  XLEN  redirect target computed in EX.
- `load_use`  in  1  ID-stage load-use hazard request.
- `pc_sel`  out  1  1 = PC takes `redirect_pc`; 0 = sequential.
- `redirect_pc`  out  XLEN  registered target.
- `pc_write`  out  1  PC register enable.
- `ifid_write`  out  1  IF/ID register enable.
- `ifid_flush`  out  1  load bubble into IF/ID.
- `idex_flush`  out  1  load bubble into ID/EX.
- `exmem_flush`  out  1  load bubble into EX/MEM.
- `redirect_cnt`  out  CNT_W  number of redirects taken, saturating.
- `stall_cnt`  out  CNT_W  number of load-use stall cycles applied, saturating.

## Operation
- Redirect event: `redir_ev = ex_valid & (do_branch | jump)`.
- Two-state FSM with states RUN and REDIRECT.
- **RUN**
  - If `redir_ev`: latch `ex_target` into `target_q`, then go to REDIRECT.
  - `load_use` is ignored in the `redir_ev` cycle because every younger instruction is wrong-path: `pc_write=1`, `ifid_write=1`, `idex_flush=0`, and `stall_cnt` does not increment.
  - Else if `load_use`: `pc_write=0`, `ifid_write=0`, `idex_flush=1`, `stall_cnt` +1.
  - Else: `pc_write=1`, `ifid_write=1`, all flushes 0.
  - In all RUN cycles: `pc_sel=0`, `ifid_flush=0`, `exmem_flush=0`.
- **REDIRECT** (exactly one cycle, then RUN)
  - `pc_sel=1`, `pc_write=1`, `ifid_write=1`.
  - `ifid_flush=1`, `idex_flush=1`, `exmem_flush=1`.
  - `do_branch`, `jump`, `ex_valid` and `load_use` are all ignored; the EX instruction is wrong-path and is squashed via `exmem_flush`.
  - `target_q` is held.
- `redirect_pc` is always `target_q`; its value is meaningful only while `pc_sel=1`.
- Counters: `redirect_cnt` +1 on each RUN→REDIRECT transition. Both counters stop at 2^CNT_W−1 and never wrap.
- Flush has priority over write: when `ifid_flush=1`, IF/ID loads a bubble even though `ifid_write=1`.
- Reset (`rst_n=0` sampled at a rising edge): state←RUN, `target_q`←0, both counters←0. A reset arriving in REDIRECT aborts the redirect.
- While `rst_n` is low, outputs are forced combinationally: `pc_write=0`, `ifid_write=0`, `pc_sel=0`, all flushes 0.

## Timing
- Redirect: `redir_ev` sampled at edge T. The REDIRECT state occupies cycle T+1, and the PC holds `ex_target` after edge T+2.
- Taken-branch/jump penalty: 3 bubbles (IF/ID, ID/EX, EX/MEM each flushed once).
- Load-use stall: combinational, in the same cycle as `load_use`. It lasts as long as `load_use` stays high (normally 1 cycle).
- Back-to-back: a `redir_ev` in the cycle immediately after REDIRECT is accepted normally.
- Counter updates are visible one cycle after the qualifying event.

## Test plan
- **Reset:** hold `rst_n=0` 3 cycles with `redir_ev=1` and `load_use=1`.
  - During reset: `pc_write=0`, `ifid_write=0`, all flushes 0.
  - After release: state RUN, counters 0, no redirect.
- **Taken BEQ:** `ex_valid=1`, `do_branch=1`, `ex_target=0x0000_0040` at edge T.
  - Cycle T+1: `pc_sel=1`, `redirect_pc=0x40`, all three flushes 1.
  - Cycle T+2: RUN; `redirect_cnt`=1.
- **Wrong-path suppression:** `jump=1` with `ex_target=0x100`, followed next cycle by `do_branch=1` with `ex_target=0x200`.
  - `redirect_pc` stays 0x100.
  - Exactly one redirect; `redirect_cnt`=1.
- **Bubble qualifier:** `ex_valid=0`, `do_branch=1` → no redirect, `pc_sel=0`, counter unchanged.
- **Load-use:** `load_use=1` for 2 cycles.
  - Both cycles: `pc_write=0`, `ifid_write=0`, `idex_flush=1`.
  - `stall_cnt`=2.
  - With `load_use` in the same cycle as `redir_ev`: `pc_write=1`, `stall_cnt` unchanged.
- **Saturation / reset mid-redirect:**
  - Preload `redirect_cnt` to 0xFFFF via 65535 redirects (or force); a further redirect leaves it at 0xFFFF.
  - Assert `rst_n=0` during REDIRECT → next cycle `pc_sel=0`, counters 0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: registered branch/jump redirect, load-use stall and flush sequencing with saturating perf counters
module branch_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             do_branch,
  input  logic             jump,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             load_use,
  output logic             pc_sel,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {RUN, REDIRECT} state_t;
  state_t            state_q, state_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d, stall_cnt_q, stall_cnt_d;
  logic              redir_ev, in_run, take, stall;
  always_comb begin
    redir_ev       = ex_valid & (do_branch | jump);
    in_run         = state_q == RUN;
    take           = in_run & redir_ev;
    stall          = in_run & ~redir_ev & load_use;
    state_d        = take ? REDIRECT : RUN;
    target_d       = take ? ex_target : target_q;
    redirect_cnt_d = take & ~&redirect_cnt_q ? redirect_cnt_q + 1'b1 : redirect_cnt_q;
    stall_cnt_d    = stall & ~&stall_cnt_q ? stall_cnt_q + 1'b1 : stall_cnt_q;
    pc_sel         = rst_n & ~in_run;
    pc_write       = rst_n & ~stall;
    ifid_write     = rst_n & ~stall;
    ifid_flush     = rst_n & ~in_run;
    idex_flush     = rst_n & (~in_run | stall);
    exmem_flush    = rst_n & ~in_run;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      target_q       <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end
  assign redirect_pc  = target_q;
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
endmodule
